// File: rtl/mux16_to_1.sv
// ---------------------------------------------------------------------------
// mux16_to_1
//
// Registered 2**SEL_W-to-1 single-bit multiplexer (16-to-1 by default).
// One bit of the input vector is picked by the select index through a
// balanced binary tree of 2:1 muxes. The result is captured in a single
// output flip-flop, so the output only changes on clock edges.
//
// Ports:
//   i_clk  - system clock, all state updates on the rising edge
//   i_rst  - synchronous, active-high reset; forces o_out to 0
//   i_in   - data inputs, i_in[k] is input k
//   i_sel  - unsigned select index, 0 picks i_in[0] (LSB)
//   o_out  - registered selected bit, valid one cycle after sampling
// ---------------------------------------------------------------------------
module mux16_to_1 #(
    parameter int SEL_W = 4,
    parameter int N     = 2 ** SEL_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N-1:0]     i_in,
    input  logic [SEL_W-1:0] i_sel,
    output logic             o_out
);

    logic w_treeOut;
    logic r_out;

    // Balanced 2:1 mux tree. Level l uses select bit l to reduce pairs
    // (node[2j], node[2j+1]) down to node[j]. The reduction is done in place
    // in ascending j order: node[j] is written only after both of its
    // children (indices 2j and 2j+1, which are >= j) have been read, so every
    // level sees only values of the previous level. After SEL_W levels,
    // node[0] holds i_in[i_sel].
    function automatic logic treeSelect(input logic [N-1:0] data,
                                        input logic [SEL_W-1:0] sel);
        logic [N-1:0] node;
        node = data;
        for (int l = 0; l < SEL_W; l++) begin
            for (int j = 0; j < (N >> (l + 1)); j++) begin
                node[j] = sel[l] ? node[2*j+1] : node[2*j];
            end
        end
        return node[0];
    endfunction

    // Combinational selection feeding the output register.
    always_comb begin
        w_treeOut = treeSelect(i_in, i_sel);
    end

    // Output register. Reset is synchronous and takes priority over the
    // selected value; there is no enable, so the output reloads every cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out <= 1'b0;
        end else begin
            r_out <= w_treeOut;
        end
    end

    assign o_out = r_out;

endmodule

// File: tb/tb_mux16_to_1.sv
// ---------------------------------------------------------------------------
// tb_mux16_to_1
//
// Self-checking bench for mux16_to_1. Each scenario task drives stimulus,
// pushes the expected registered output into a scoreboard queue when the
// stimulus is applied, and pops/compares it just after the capturing edge.
// ---------------------------------------------------------------------------
module tb_mux16_to_1;

    logic        clk;
    logic        rst;
    logic [15:0] inVec;
    logic [3:0]  sel;
    logic        out;

    logic        expQ[$];
    int          passCount;
    int          checkCount;

    mux16_to_1 #(.SEL_W(4)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .i_in  (inVec),
        .i_sel (sel),
        .o_out (out)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reset held for two edges, release, then a between-edge rst pulse that
    // must not disturb the output until the next edge.
    task automatic test_reset();
        logic exp;
        rst   = 1'b1;
        inVec = 16'hFFFF;
        sel   = 4'h5;
        for (int i = 0; i < 2; i++) begin
            expQ.push_back(1'b0);
            @(posedge clk); #1;
            exp = expQ.pop_front();
            checkCount++;
            if (out !== exp)
                $display("[TB] FAIL reset_hold[%0d]: actual=%b required=%b", i, out, exp);
            else
                passCount++;
        end
        rst = 1'b0;
        expQ.push_back(1'b1);
        @(posedge clk); #1;
        exp = expQ.pop_front();
        checkCount++;
        if (out !== exp)
            $display("[TB] FAIL reset_release: actual=%b required=%b", out, exp);
        else
            passCount++;
        #2 rst = 1'b1;
        #2;
        checkCount++;
        if (out !== 1'b1)
            $display("[TB] FAIL reset_sync_only: actual=%b required=%b", out, 1'b1);
        else
            passCount++;
        expQ.push_back(1'b0);
        @(posedge clk); #1;
        exp = expQ.pop_front();
        checkCount++;
        if (out !== exp)
            $display("[TB] FAIL reset_async_edge: actual=%b required=%b", out, exp);
        else
            passCount++;
        rst = 1'b0;
    endtask

    // Fixed pattern swept over every select value; the expected sequence is
    // the bit pattern of 16'h3F0A read LSB first.
    task automatic test_full_sweep();
        logic sweepExp[16] = '{0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0};
        logic exp;
        inVec = 16'h3F0A;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            expQ.push_back(sweepExp[s]);
            @(posedge clk); #1;
            exp = expQ.pop_front();
            checkCount++;
            if (out !== exp)
                $display("[TB] FAIL full_sweep sel=%0d: actual=%b required=%b", s, out, exp);
            else
                passCount++;
        end
    endtask

    // Walking one across all inputs, each swept over every select value.
    task automatic test_walking_one();
        logic exp;
        for (int k = 0; k < 16; k++) begin
            inVec = 16'h0001 << k;
            for (int s = 0; s < 16; s++) begin
                sel = 4'(s);
                expQ.push_back(s == k);
                @(posedge clk); #1;
                exp = expQ.pop_front();
                checkCount++;
                if (out !== exp)
                    $display("[TB] FAIL walking_one k=%0d sel=%0d: actual=%b required=%b", k, s, out, exp);
                else
                    passCount++;
            end
        end
    endtask

    // Toggling unselected bits with bit 9 held high, then clearing bit 9.
    task automatic test_isolation();
        logic [15:0] pattern[5] = '{16'h0200, 16'hFFFF, 16'h0200, 16'hFFFF, 16'hFDFF};
        logic        isoExp[5]  = '{1, 1, 1, 1, 0};
        logic        exp;
        sel = 4'h9;
        for (int i = 0; i < 5; i++) begin
            inVec = pattern[i];
            expQ.push_back(isoExp[i]);
            @(posedge clk); #1;
            exp = expQ.pop_front();
            checkCount++;
            if (out !== exp)
                $display("[TB] FAIL isolation in=%h: actual=%b required=%b", pattern[i], out, exp);
            else
                passCount++;
        end
    endtask

    // Sweep interrupted by a one-edge reset at sel=B, resumed at sel=C.
    task automatic test_reset_mid_sweep();
        logic sweepExp[16] = '{0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0};
        logic exp;
        inVec = 16'h3F0A;
        for (int s = 0; s < 16; s++) begin
            sel = 4'(s);
            rst = (s == 11);
            expQ.push_back((s == 11) ? 1'b0 : sweepExp[s]);
            @(posedge clk); #1;
            exp = expQ.pop_front();
            checkCount++;
            if (out !== exp)
                $display("[TB] FAIL reset_mid_sweep sel=%0d: actual=%b required=%b", s, out, exp);
            else
                passCount++;
        end
        rst = 1'b0;
    endtask

    // Select change shortly before an edge: old value until the edge, new
    // value right after it. Inputs also change together back to back.
    task automatic test_back_to_back();
        logic exp;
        inVec = 16'h0002;
        sel   = 4'h0;
        expQ.push_back(1'b0);
        @(posedge clk); #1;
        exp = expQ.pop_front();
        checkCount++;
        if (out !== exp)
            $display("[TB] FAIL latency_pre: actual=%b required=%b", out, exp);
        else
            passCount++;
        #6 sel = 4'h1;
        expQ.push_back(1'b1);
        #2;
        checkCount++;
        if (out !== 1'b0)
            $display("[TB] FAIL latency_before_edge: actual=%b required=%b", out, 1'b0);
        else
            passCount++;
        @(posedge clk); #1;
        exp = expQ.pop_front();
        checkCount++;
        if (out !== exp)
            $display("[TB] FAIL latency_after_edge: actual=%b required=%b", out, exp);
        else
            passCount++;
        // Simultaneous in/sel change: new select applied to new data.
        inVec = 16'h8000;
        sel   = 4'hF;
        expQ.push_back(1'b1);
        @(posedge clk); #1;
        inVec = 16'h7FFF;
        sel   = 4'hF;
        expQ.push_back(1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            exp = expQ.pop_front();
            checkCount++;
            if (i == 0) begin
                if (1'b1 !== exp)
                    $display("[TB] FAIL simultaneous_queue: actual=%b required=%b", 1'b1, exp);
                else
                    passCount++;
            end else begin
                if (out !== exp)
                    $display("[TB] FAIL simultaneous_change: actual=%b required=%b", out, exp);
                else
                    passCount++;
            end
        end
    endtask

    initial begin
        passCount  = 0;
        checkCount = 0;
        rst   = 1'b1;
        inVec = 16'h0000;
        sel   = 4'h0;
        @(negedge clk);
        $display("[TB] starting mux16_to_1 checks");
        test_reset();
        test_full_sweep();
        test_walking_one();
        test_isolation();
        test_reset_mid_sweep();
        test_back_to_back();
        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard_drain: actual=%0d required=0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
